// File: rtl/waveform_buffer_storage_v2.sv
// Waveform sample RAM (read-first, 1-cycle latency) plus standard header FIFO with exact count and sticky errors.
// Optional build macro WVB_STORAGE_PARITY_EN stores an even-parity bit per RAM word and flags mismatches on read.
module waveform_buffer_storage_v2 #(
  parameter int P_DATA_WIDTH    = 28,
  parameter int P_ADR_WIDTH     = 15,
  parameter int P_HDR_WIDTH     = 87,
  parameter int P_HDR_ADR_WIDTH = 10
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       eoe_in,
  input  logic [P_DATA_WIDTH-1:0]    wvb_data_in,
  input  logic [P_ADR_WIDTH-1:0]     wvb_wr_addr,
  input  logic                       wvb_wrreq,
  input  logic [P_ADR_WIDTH-1:0]     wvb_rd_addr,
  output logic [P_DATA_WIDTH-1:0]    wvb_data_out,
  output logic                       wvb_parity_err,
  input  logic [P_HDR_WIDTH-1:0]     hdr_data_in,
  input  logic                       hdr_wrreq,
  input  logic                       hdr_rdreq,
  output logic [P_HDR_WIDTH-1:0]     hdr_data_out,
  output logic                       hdr_full,
  output logic                       hdr_empty,
  output logic [P_HDR_ADR_WIDTH:0]   n_wvf_in_buf,
  output logic                       hdr_overflow,
  output logic                       hdr_underflow,
  input  logic                       err_clr
);

  localparam int RAM_DEPTH = 2 ** P_ADR_WIDTH;
  localparam int HDEPTH    = 2 ** P_HDR_ADR_WIDTH;
  localparam int CNT_W     = P_HDR_ADR_WIDTH + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = {1'b1, {P_HDR_ADR_WIDTH{1'b0}}};
`ifdef WVB_STORAGE_PARITY_EN
  localparam int RAM_W = P_DATA_WIDTH + 1;
`else
  localparam int RAM_W = P_DATA_WIDTH;
`endif

  // ---------------- waveform sample RAM ----------------
  logic [RAM_W-1:0]        wvb_mem_q [RAM_DEPTH];
  logic [RAM_W-1:0]        rd_word_q;
  logic [P_DATA_WIDTH-1:0] wr_data;
  logic [RAM_W-1:0]        ram_wr_word;

  // Bit 0 of the incoming sample is replaced by the end-of-event marker.
  always_comb begin
    wr_data    = wvb_data_in;
    wr_data[0] = eoe_in;
`ifdef WVB_STORAGE_PARITY_EN
    ram_wr_word = {^wr_data, wr_data};
`else
    ram_wr_word = wr_data;
`endif
  end

  always_ff @(posedge clk) begin
    if (wvb_wrreq) begin
      wvb_mem_q[wvb_wr_addr] <= ram_wr_word;
    end
  end

  // Non-blocking read of the array gives read-first behaviour on address collision.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_word_q <= '0;
    end else begin
      rd_word_q <= wvb_mem_q[wvb_rd_addr];
    end
  end

  assign wvb_data_out = rd_word_q[P_DATA_WIDTH-1:0];
`ifdef WVB_STORAGE_PARITY_EN
  assign wvb_parity_err = ^rd_word_q;
`else
  assign wvb_parity_err = 1'b0;
`endif

  // ---------------- header FIFO ----------------
  logic [P_HDR_WIDTH-1:0]     hdr_mem_q [HDEPTH];
  logic [P_HDR_ADR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [P_HDR_ADR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]           count_q, count_d;
  logic                       full_q, full_d;
  logic                       empty_q, empty_d;
  logic                       ovf_q, ovf_d;
  logic                       unf_q, unf_d;
  logic [P_HDR_WIDTH-1:0]     hdr_out_q;
  logic                       push_acc, pop_acc;

  always_comb begin
    pop_acc  = hdr_rdreq && !empty_q && !rst;
    push_acc = hdr_wrreq && (!full_q || pop_acc) && !rst;
    wr_ptr_d = push_acc ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop_acc  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q;
    if (push_acc && !pop_acc) begin
      count_d = count_q + 1'b1;
    end else if (pop_acc && !push_acc) begin
      count_d = count_q - 1'b1;
    end
    full_d  = (count_d == CNT_FULL);
    empty_d = (count_d == '0);
    // A new error in the same cycle as err_clr keeps the flag set.
    ovf_d = (hdr_wrreq && !push_acc) || (ovf_q && !err_clr);
    unf_d = (hdr_rdreq && !pop_acc)  || (unf_q && !err_clr);
  end

  always_ff @(posedge clk) begin
    if (push_acc) begin
      hdr_mem_q[wr_ptr_q] <= hdr_data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      full_q    <= 1'b0;
      empty_q   <= 1'b1;
      ovf_q     <= 1'b0;
      unf_q     <= 1'b0;
      hdr_out_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
      if (pop_acc) begin
        hdr_out_q <= hdr_mem_q[rd_ptr_q];
      end
    end
  end

  assign hdr_data_out  = hdr_out_q;
  assign hdr_full      = full_q;
  assign hdr_empty     = empty_q;
  assign n_wvf_in_buf  = count_q;
  assign hdr_overflow  = ovf_q;
  assign hdr_underflow = unf_q;

endmodule
